// File: rtl/lock_pkg.sv
// Shared state encoding, side constants and sizing helper for the two-door lock sequencer.
package lock_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    PRE_MOVE = 4'd1,
    OPEN_A   = 4'd2,
    SHUT_A   = 4'd3,
    MOVE     = 4'd4,
    OPEN_B   = 4'd5,
    SHUT_B   = 4'd6,
    ABORT    = 4'd7,
    ERROR    = 4'd8
  } state_t;

  localparam logic SIDE_IN  = 1'b0;
  localparam logic SIDE_OUT = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/req_counter.sv
// Saturating pending-request counter; an increment and a decrement in the same cycle cancel out.
module req_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  // NOTE: sequential state is only ever written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec && count != '1) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lock_scheduler.sv
// Water lock chamber sequencer: arbitrates queued boat requests and steps doors and valves
// through fixed-length phases with boat sensor handshakes.
module lock_scheduler
  import lock_pkg::*;
#(
  parameter int CNT_W    = 3,
  parameter int MOVE_CYC = 16,
  parameter int DOOR_CYC = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             boat_enter,
  input  logic             boat_exit,
  output logic             iport_open,
  output logic             oport_open,
  output logic             fill_cmd,
  output logic             drain_cmd,
  output logic             level_hi,
  output logic             busy,
  output logic             serve_out,
  output logic [CNT_W-1:0] pend_in,
  output logic [CNT_W-1:0] pend_out,
  output logic             err
);

  localparam int TMR_W = $clog2(max3(MOVE_CYC, DOOR_CYC, TIMEOUT) + 1);
  localparam logic [TMR_W-1:0] MOVE_END = TMR_W'(MOVE_CYC - 1);
  localparam logic [TMR_W-1:0] DOOR_END = TMR_W'(DOOR_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_END = TMR_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [TMR_W-1:0] timer;
  logic             serve, serve_nx;
  logic             level, level_nx;
  logic             consume;
  logic             dec_in, dec_out;
  logic             any_in, any_out;

  assign any_in  = (pend_in != '0);
  assign any_out = (pend_out != '0);
  assign dec_in  = consume && (serve == SIDE_IN);
  assign dec_out = consume && (serve == SIDE_OUT);

  req_counter #(.W(CNT_W)) u_cnt_in (
    .clock (clock),
    .reset (reset),
    .inc   (req_in),
    .dec   (dec_in),
    .count (pend_in)
  );

  req_counter #(.W(CNT_W)) u_cnt_out (
    .clock (clock),
    .reset (reset),
    .inc   (req_out),
    .dec   (dec_out),
    .count (pend_out)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    serve_nx = serve;
    level_nx = level;
    consume  = 1'b0;
    case (state)
      IDLE: begin
        if (any_in || any_out) begin
          // With both sides waiting, serve the side already matching the water level.
          serve_nx = (any_in && any_out) ? level : any_out;
          state_nx = (serve_nx == level) ? OPEN_A : PRE_MOVE;
        end
      end
      PRE_MOVE: begin
        if (timer == MOVE_END) begin
          level_nx = serve;
          state_nx = OPEN_A;
        end
      end
      OPEN_A: begin
        if (boat_enter) begin
          consume  = 1'b1;
          state_nx = SHUT_A;
        end else if (timer == WAIT_END) begin
          consume  = 1'b1;
          state_nx = ABORT;
        end
      end
      SHUT_A: if (timer == DOOR_END) state_nx = MOVE;
      MOVE: begin
        if (timer == MOVE_END) begin
          level_nx = ~level;
          state_nx = OPEN_B;
        end
      end
      OPEN_B: begin
        if (boat_exit)               state_nx = SHUT_B;
        else if (timer == WAIT_END)  state_nx = ERROR;
      end
      SHUT_B:  if (timer == DOOR_END) state_nx = IDLE;
      ABORT:   if (timer == DOOR_END) state_nx = IDLE;
      ERROR:   state_nx = ERROR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      serve <= SIDE_IN;
      level <= 1'b0;
    end else begin
      state <= state_nx;
      serve <= serve_nx;
      level <= level_nx;
      // Timer restarts on every phase change; it rests at zero where no phase is timed.
      if (state_nx != state || state == IDLE || state == ERROR) timer <= '0;
      else                                                      timer <= timer + 1'b1;
    end
  end

  logic entry_open, exit_open;
  assign entry_open = (state == OPEN_A);
  assign exit_open  = (state == OPEN_B) || (state == ERROR);

  assign iport_open = (entry_open && serve == SIDE_IN)  || (exit_open && serve == SIDE_OUT);
  assign oport_open = (entry_open && serve == SIDE_OUT) || (exit_open && serve == SIDE_IN);
  assign fill_cmd   = (state == PRE_MOVE && serve == SIDE_OUT) || (state == MOVE && serve == SIDE_IN);
  assign drain_cmd  = (state == PRE_MOVE && serve == SIDE_IN)  || (state == MOVE && serve == SIDE_OUT);
  assign level_hi   = level;
  assign busy       = (state != IDLE);
  assign serve_out  = serve;
  assign err        = (state == ERROR);

endmodule

// File: tb/tb_lock_scheduler.sv
// Randomized scoreboard bench: a phase-script model predicts every cycle's outputs and counts.
module tb_lock_scheduler;

  localparam int CNT_MAX    = 7;
  localparam int MOVE_N     = 16;
  localparam int DOOR_N     = 4;
  localparam int WAIT_N     = 64;
  localparam int IDLE_LIMIT = 4000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_in = 1'b0, req_out = 1'b0, boat_enter = 1'b0, boat_exit = 1'b0;
  logic       iport_open, oport_open, fill_cmd, drain_cmd, level_hi, busy, serve_out, err;
  logic [2:0] pend_in, pend_out;

  lock_scheduler #(.CNT_W(3), .MOVE_CYC(MOVE_N), .DOOR_CYC(DOOR_N), .TIMEOUT(WAIT_N)) dut (
    .clock(clock), .reset(reset), .req_in(req_in), .req_out(req_out),
    .boat_enter(boat_enter), .boat_exit(boat_exit),
    .iport_open(iport_open), .oport_open(oport_open), .fill_cmd(fill_cmd), .drain_cmd(drain_cmd),
    .level_hi(level_hi), .busy(busy), .serve_out(serve_out),
    .pend_in(pend_in), .pend_out(pend_out), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic iport, oport, fill, drain, level, busy, err;} outs_t;
  typedef struct {outs_t o; logic serve; bit drv_enter, drv_exit, consume; int kind;} slot_t;
  typedef struct {outs_t o; logic serve; int pin, pout;} exp_t;

  slot_t plan[$];
  exp_t  sb[$];
  exp_t  mon_e;
  int    vectors = 0, miscompares = 0;

  int    m_pin, m_pout;
  logic  m_level, m_err_serve;
  bit    m_error;
  outs_t m_err_o;
  int    force_e = -1, force_x = -1, abort_pct = 0;
  bit    coincide_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int next_count(input int c, input bit inc, input bit dec);
    if (inc && !dec) return (c < CNT_MAX) ? c + 1 : c;
    if (dec && !inc) return (c > 0) ? c - 1 : c;
    return c;
  endfunction

  // Appends n cycles of one phase; the flags apply to the phase's last cycle only.
  task automatic add(input int n, input logic side, input logic ip, input logic op,
                     input logic fl, input logic dr, input int kind,
                     input bit last_enter, input bit last_exit, input bit last_cons);
    slot_t s;
    for (int i = 0; i < n; i++) begin
      s.o         = {ip, op, fl, dr, m_level, 1'b1, 1'b0};
      s.serve     = side;
      s.kind      = kind;
      s.drv_enter = last_enter && (i == n - 1);
      s.drv_exit  = last_exit && (i == n - 1);
      s.consume   = last_cons && (i == n - 1);
      plan.push_back(s);
    end
  endtask

  // Script for one whole service of side s; e/x are sensor delays, -2 means the boat never moves.
  task automatic build_plan(input logic s);
    int e, x;
    e = force_e; x = force_x; force_e = -1; force_x = -1;
    if (e == -1) e = ($urandom_range(0, 99) < abort_pct) ? -2 : int'($urandom_range(0, 15));
    if (x == -1) x = $urandom_range(0, 15);
    if (s != m_level) begin
      add(MOVE_N, s, 1'b0, 1'b0, s, !s, 0, 0, 0, 0);
      m_level = s;
    end
    if (e == -2) begin
      add(WAIT_N, s, !s, s, 1'b0, 1'b0, 1, 0, 0, 1);
      add(DOOR_N, s, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      return;
    end
    add(e + 1, s, !s, s, 1'b0, 1'b0, 1, 1, 0, 1);
    add(DOOR_N, s, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    add(MOVE_N, s, 1'b0, 1'b0, !s, s, 0, 0, 0, 0);
    m_level = !m_level;
    if (x == -2) begin
      add(WAIT_N, s, s, !s, 1'b0, 1'b0, 2, 0, 0, 0);
      m_error     = 1'b1;
      m_err_o     = {s, !s, 1'b0, 1'b0, m_level, 1'b1, 1'b1};
      m_err_serve = s;
      return;
    end
    add(x + 1, s, s, !s, 1'b0, 1'b0, 2, 0, 1, 0);
    add(DOOR_N, s, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic step(input bit ri, input bit ro);
    slot_t cur;
    exp_t  e;
    bit    idle;
    @(posedge clock); #1;
    idle = 1'b0;
    if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else begin
      cur.o         = m_error ? m_err_o : {4'b0000, m_level, 1'b0, 1'b0};
      cur.serve     = m_error ? m_err_serve : 1'b0;
      cur.drv_enter = 1'b0; cur.drv_exit = 1'b0; cur.consume = 1'b0; cur.kind = 0;
      idle          = !m_error;
    end
    req_in  = ri;
    req_out = ro;
    if (coincide_req && cur.drv_enter) begin
      req_in = 1'b1;
      coincide_req = 1'b0;
    end
    // Stray sensor pulses outside the phase that listens for them must be ignored.
    boat_enter = cur.drv_enter || (cur.kind != 1 && $urandom_range(0, 15) == 0);
    boat_exit  = cur.drv_exit  || (cur.kind != 2 && $urandom_range(0, 15) == 0);
    e.o = cur.o; e.serve = cur.serve; e.pin = m_pin; e.pout = m_pout;
    sb.push_back(e);
    if (idle && (m_pin != 0 || m_pout != 0))
      build_plan((m_pin != 0 && m_pout != 0) ? m_level : logic'(m_pout != 0));
    m_pin  = next_count(m_pin,  req_in,  cur.consume && cur.serve == 1'b0);
    m_pout = next_count(m_pout, req_out, cur.consume && cur.serve == 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((plan.size() > 0 || m_pin != 0 || m_pout != 0) && n < IDLE_LIMIT) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (n >= IDLE_LIMIT) begin
      miscompares++;
      $display("FAIL idle_bound: model still busy after %0d cycles", n);
    end
  endtask

  task automatic reset_model();
    m_pin = 0; m_pout = 0; m_level = 1'b0; m_error = 1'b0;
    m_err_o = '0; m_err_serve = 1'b0;
    plan.delete(); sb.delete();
    force_e = -1; force_x = -1; coincide_req = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outs"}, {24'b0, iport_open, oport_open, fill_cmd, drain_cmd,
                           level_hi, busy, serve_out, err}, 32'd0);
    check({tag, "_pend_in"}, 32'(pend_in), 32'd0);
    check({tag, "_pend_out"}, 32'(pend_out), 32'd0);
  endtask

  // Monitor: invariants every cycle, then pop and compare the predicted cycle.
  always @(negedge clock) begin
    if (reset) begin
      assert (!(iport_open && oport_open)) else begin
        miscompares++; $display("FAIL inv_doors: both doors open at %0t", $time);
      end
      assert (!(fill_cmd && drain_cmd)) else begin
        miscompares++; $display("FAIL inv_valves: fill and drain together at %0t", $time);
      end
      assert (!((fill_cmd || drain_cmd) && (iport_open || oport_open))) else begin
        miscompares++; $display("FAIL inv_valve_door: valve on with door open at %0t", $time);
      end
    end
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("outputs", {25'b0, iport_open, oport_open, fill_cmd, drain_cmd, level_hi, busy, err},
            {25'b0, mon_e.o});
      check("pend_in", 32'(pend_in), 32'(mon_e.pin));
      check("pend_out", 32'(pend_out), 32'(mon_e.pout));
      if (mon_e.o.busy) check("serve_out", 32'(serve_out), 32'(mon_e.serve));
    end
  end

  initial begin
    int n;
    reset_model();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state("reset");
    reset = 1'b1;

    // Inner boat at low water: enter on the 10th OPEN_A cycle, exit on the 5th OPEN_B cycle.
    force_e = 9; force_x = 4;
    step(1'b1, 1'b0); wait_idle();
    // Outer boat at high water, then again at low water (needs a pre-fill).
    step(1'b0, 1'b1); wait_idle();
    step(1'b0, 1'b1); wait_idle();
    // Both sides at once at low water: inner first, outer follows without pre-move.
    step(1'b1, 1'b1); wait_idle();
    // Saturation, plus one request coincident with a boat_enter.
    coincide_req = 1'b1;
    repeat (10) step(1'b1, 1'b0);
    wait_idle();
    // Entry timeout.
    force_e = -2;
    step(1'b1, 1'b0); wait_idle();
    // Random traffic with occasional entry timeouts.
    abort_pct = 15;
    repeat (2000) step($urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
    wait_idle();
    abort_pct = 0;
    // Exit timeout into ERROR, then an asynchronous reset between clock edges.
    force_x = -2;
    step(1'b0, 1'b1);
    n = 0;
    while (!(m_error && plan.size() == 0) && n < IDLE_LIMIT) begin
      step(1'b0, 1'b0);
      n++;
    end
    if (n >= IDLE_LIMIT) begin
      miscompares++;
      $display("FAIL error_bound: ERROR not reached by model after %0d cycles", n);
    end
    repeat (8) step(1'b0, 1'b0);
    @(posedge clock); #2;
    req_in = 1'b0; req_out = 1'b0; boat_enter = 1'b0; boat_exit = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    reset_model();
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 1'b0); wait_idle();

    @(negedge clock);
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
